// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
// Optional build macro MEM_TIMEOUT_EN enables the wait timer in mem_access_ctrl.
package mem_ctrl_pkg;

    // Default data/address width of the pipeline.
    localparam int DATA_W_DEF = 16;

    // Load data reported after a timed-out access (sliced to DATA_W at use).
    localparam logic [63:0] TIMEOUT_DATA = '1;

    // Access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_access_ctrl_wait_timer.sv
// Wait-cycle counter with limit compare for the MEM-stage access controller.
// Instantiated only when MEM_TIMEOUT_EN is defined.
module mem_wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,   // entering WAIT
    input  logic en_i,    // WAIT cycle with no ack
    output logic hit_o    // this cycle reaches the limit
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = cnt_q + 1'b1;
    assign hit_o = en_i && (cnt_d == CNT_W'(MAX_WAIT));

    // Count un-acknowledged WAIT cycles; restart on every new access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer: one req/ack transaction per valid
// load/store, upstream stall until ack, MEM/WB bubble steering.
// Optional build macro MEM_TIMEOUT_EN bounds WAIT to MAX_WAIT cycles.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              L_in,
    input  logic              S_in,
    input  logic              invalid_in,
    input  logic [DATA_W-1:0] mem_addr_in,
    input  logic [DATA_W-1:0] mem_wdata_in,
    input  logic              flush_req_in,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              dm_req,
    output logic              dm_we,
    output logic [DATA_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_data_out,
    output logic              pipe_stall,
    output logic              MEM_WB_Write,
    output logic              MEM_FLUSH,
    output logic              busy,
    output logic              dm_timeout
);

    state_e            state_q;
    logic              dm_req_q;
    logic              dm_we_q;
    logic [DATA_W-1:0] dm_addr_q;
    logic [DATA_W-1:0] dm_wdata_q;
    logic [DATA_W-1:0] dm_data_q;

    logic acc;
    logic ack_ok;
    logic start;
    logic tmo_hit;
    logic tmo_q;

    assign acc    = (L_in | S_in) & ~invalid_in;
    // An ack only counts while a request is actually outstanding.
    assign ack_ok = dm_ack & dm_req_q;
    assign start  = (state_q == ST_IDLE) && acc;

`ifdef MEM_TIMEOUT_EN
    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (start),
        .en_i  ((state_q == ST_WAIT) && !ack_ok),
        .hit_o (tmo_hit)
    );
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT > 0);
    assign tmo_hit         = 1'b0;
`endif

    // Sequencer FSM with registered memory-interface outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            dm_data_q  <= '0;
            tmo_q      <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (acc) begin
                        dm_addr_q  <= mem_addr_in;
                        dm_wdata_q <= mem_wdata_in;
                        dm_we_q    <= S_in;
                        dm_req_q   <= 1'b1;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A same-cycle ack takes priority over the timeout.
                    if (ack_ok) begin
                        dm_req_q <= 1'b0;
                        if (!dm_we_q) begin
                            dm_data_q <= dm_rdata;
                        end
                        state_q <= ST_DONE;
                    end else if (tmo_hit) begin
                        dm_req_q  <= 1'b0;
                        dm_data_q <= TIMEOUT_DATA[DATA_W-1:0];
                        tmo_q     <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // EX/MEM still holds the finished op; never restart here.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    dm_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Pipeline steering decoded from state (and acc/flush in non-busy states).
    always_comb begin
        pipe_stall   = 1'b0;
        MEM_WB_Write = 1'b1;
        MEM_FLUSH    = flush_req_in;
        case (state_q)
            ST_IDLE: begin
                if (acc) begin
                    pipe_stall = 1'b1;
                    MEM_FLUSH  = 1'b1;
                end
            end
            ST_WAIT: begin
                pipe_stall = 1'b1;
                MEM_FLUSH  = 1'b1;
            end
            ST_DONE: begin
                // Aborted access must not retire into WB.
                MEM_FLUSH = flush_req_in | tmo_q;
            end
            default: ;
        endcase
    end

    assign dm_req      = dm_req_q;
    assign busy        = dm_req_q;
    assign dm_we       = dm_we_q;
    assign dm_addr     = dm_addr_q;
    assign dm_wdata    = dm_wdata_q;
    assign dm_data_out = dm_data_q;

`ifdef MEM_TIMEOUT_EN
    assign dm_timeout = tmo_q;
`else
    assign dm_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; add MEM_TIMEOUT_EN to also run the timeout case.
module tb_mem_access_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          L_in, S_in, invalid_in, flush_req_in, dm_ack;
    logic [DW-1:0] mem_addr_in, mem_wdata_in, dm_rdata;
    logic          dm_req, dm_we, pipe_stall, MEM_WB_Write, MEM_FLUSH, busy, dm_timeout;
    logic [DW-1:0] dm_addr, dm_wdata, dm_data_out;

    int checks   = 0;
    int failures = 0;

    mem_access_ctrl #(.DATA_W(DW), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .L_in         (L_in),
        .S_in         (S_in),
        .invalid_in   (invalid_in),
        .mem_addr_in  (mem_addr_in),
        .mem_wdata_in (mem_wdata_in),
        .flush_req_in (flush_req_in),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_data_out  (dm_data_out),
        .pipe_stall   (pipe_stall),
        .MEM_WB_Write (MEM_WB_Write),
        .MEM_FLUSH    (MEM_FLUSH),
        .busy         (busy),
        .dm_timeout   (dm_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Move to the next cycle: inputs change 1 time unit after the rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Sample combinational/registered outputs mid-cycle.
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic ctl(input string tag, input logic st, input logic fl, input logic rq);
        chk({tag, ".stall"}, 32'(pipe_stall), 32'(st));
        chk({tag, ".wb"},    32'(MEM_WB_Write), 32'd1);
        chk({tag, ".flush"}, 32'(MEM_FLUSH), 32'(fl));
        chk({tag, ".req"},   32'(dm_req), 32'(rq));
        chk({tag, ".busy"},  32'(busy), 32'(rq));
    endtask

    initial begin
        rst_n = 1'b0; L_in = 0; S_in = 0; invalid_in = 0; flush_req_in = 0;
        dm_ack = 0; dm_rdata = '0; mem_addr_in = '0; mem_wdata_in = '0;

        // Reset state
        smp();
        ctl("rst", 1'b0, 1'b0, 1'b0);
        chk("rst.we",   32'(dm_we), 32'd0);
        chk("rst.addr", 32'(dm_addr), 32'd0);
        chk("rst.data", 32'(dm_data_out), 32'd0);
        chk("rst.tmo",  32'(dm_timeout), 32'd0);
        nxt();
        rst_n = 1'b1;

        // ALU pass-through, including an invalid load and a squash request
        for (int i = 0; i < 3; i++) begin
            smp(); ctl("alu", 1'b0, 1'b0, 1'b0);
            nxt();
        end
        L_in = 1; invalid_in = 1; flush_req_in = 1;
        smp(); ctl("bubble", 1'b0, 1'b1, 1'b0);
        nxt();
        L_in = 0; invalid_in = 0; flush_req_in = 0;
        smp(); ctl("bubble.after", 1'b0, 1'b0, 1'b0);
        nxt();

        // Load 0x0040, ack on second WAIT cycle
        L_in = 1; mem_addr_in = 16'h0040;
        smp(); ctl("ld.idle", 1'b1, 1'b1, 1'b0);
        nxt();
        smp(); ctl("ld.w1", 1'b1, 1'b1, 1'b1);
        chk("ld.we",   32'(dm_we), 32'd0);
        chk("ld.addr", 32'(dm_addr), 32'h0040);
        nxt();
        dm_ack = 1; dm_rdata = 16'hBEEF; flush_req_in = 1;
        smp(); ctl("ld.w2", 1'b1, 1'b1, 1'b1);
        nxt();
        dm_ack = 0; dm_rdata = '0; flush_req_in = 0;
        smp(); ctl("ld.done", 1'b0, 1'b0, 1'b0);
        chk("ld.data", 32'(dm_data_out), 32'hBEEF);
        nxt();
        L_in = 0;
        smp(); ctl("ld.norestart", 1'b0, 1'b0, 1'b0);
        nxt();

        // Store 0x1234 -> 0x0100, ack in first WAIT cycle
        S_in = 1; mem_addr_in = 16'h0100; mem_wdata_in = 16'h1234;
        smp(); ctl("st.idle", 1'b1, 1'b1, 1'b0);
        nxt();
        dm_ack = 1; dm_rdata = 16'h9999;
        smp(); ctl("st.w1", 1'b1, 1'b1, 1'b1);
        chk("st.we",    32'(dm_we), 32'd1);
        chk("st.addr",  32'(dm_addr), 32'h0100);
        chk("st.wdata", 32'(dm_wdata), 32'h1234);
        nxt();
        dm_ack = 0;
        smp(); ctl("st.done", 1'b0, 1'b0, 1'b0);
        chk("st.data", 32'(dm_data_out), 32'hBEEF);
        nxt();

        // Back-to-back load 0x0200 then store 0xCAFE -> 0x0300
        S_in = 0; L_in = 1; mem_addr_in = 16'h0200;
        nxt();
        dm_ack = 1; dm_rdata = 16'h5A5A;
        nxt();
        dm_ack = 0;
        smp(); ctl("b2b.done1", 1'b0, 1'b0, 1'b0);
        chk("b2b.data1", 32'(dm_data_out), 32'h5A5A);
        nxt();
        L_in = 0; S_in = 1; mem_addr_in = 16'h0300; mem_wdata_in = 16'hCAFE;
        smp(); ctl("b2b.idle2", 1'b1, 1'b1, 1'b0);
        nxt();
        dm_ack = 1;
        smp(); ctl("b2b.w2", 1'b1, 1'b1, 1'b1);
        chk("b2b.addr2", 32'(dm_addr), 32'h0300);
        chk("b2b.we2",   32'(dm_we), 32'd1);
        nxt();
        dm_ack = 0;
        smp(); ctl("b2b.done2", 1'b0, 1'b0, 1'b0);
        chk("b2b.data2", 32'(dm_data_out), 32'h5A5A);
        nxt();
        S_in = 0;

        // Async reset in the middle of WAIT
        L_in = 1; mem_addr_in = 16'h0044;
        nxt();
        smp(); chk("rw.req", 32'(dm_req), 32'd1);
        nxt();
        rst_n = 1'b0;
        #1;
        chk("rw.req0",  32'(dm_req), 32'd0);
        chk("rw.busy0", 32'(busy), 32'd0);
        nxt();
        rst_n = 1'b1; L_in = 0; dm_ack = 1; dm_rdata = 16'h7777;
        smp(); ctl("rw.spur", 1'b0, 1'b0, 1'b0);
        nxt();
        dm_ack = 0;
        smp(); ctl("rw.after", 1'b0, 1'b0, 1'b0);
        chk("rw.data", 32'(dm_data_out), 32'd0);
        nxt();

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after the 4th WAIT cycle
        L_in = 1; mem_addr_in = 16'h0500;
        nxt();
        for (int i = 0; i < 4; i++) begin
            smp(); ctl("to.wait", 1'b1, 1'b1, 1'b1);
            chk("to.tmo0", 32'(dm_timeout), 32'd0);
            nxt();
        end
        smp(); ctl("to.done", 1'b0, 1'b1, 1'b0);
        chk("to.tmo",  32'(dm_timeout), 32'd1);
        chk("to.data", 32'(dm_data_out), 32'hFFFF);
        nxt();
        L_in = 0;
        smp(); chk("to.tmoclr", 32'(dm_timeout), 32'd0);
        nxt();
`else
        smp(); chk("tmo.tied", 32'(dm_timeout), 32'd0);
        nxt();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so a stuck run still ends.
    initial begin
        #100000;
        $display("FAIL timeout: bench exceeded time budget");
        $fatal(1);
    end

endmodule
